pipelined_functional_unit: RTL and testbench

PIPELINED_FUNCTIONAL_UNIT -- requirements
Module: pipelined_functional_unit

---
 rtl/pipelined_functional_unit_if.sv | 35 +++
 rtl/pipelined_functional_unit.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_pipelined_functional_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_functional_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_functional_unit_if
// Description : Operation/result handshake bundle for pipelined_functional_unit.
//               master = operation producer / result consumer,
//               slave  = the functional unit.
//   IN_VALID/IN_READY   operation handshake, A/B/C operands, INST opcode
//   OUT_VALID/OUT_READY result handshake, Z result, FLAGS {N,Zf,C,V}
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_functional_unit_if #(
    parameter int WIDTH = 32
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [4:0]       INST;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Z;
    logic [3:0]       FLAGS;

    modport master (
        output IN_VALID, A, B, C, INST, OUT_READY,
        input  IN_READY, OUT_VALID, Z, FLAGS
    );

    modport slave (
        input  IN_VALID, A, B, C, INST, OUT_READY,
        output IN_READY, OUT_VALID, Z, FLAGS
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_functional_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_functional_unit
// Description : Single-issue functional unit with ALU, barrel shifter and a
//               pipelined multiply-add. ALU/shifter/reserved ops complete in
//               one cycle; MADD takes MADD_STAGES+1 cycles. One op in flight.
//   CLOCK  : clock, rising edge
//   RESET  : asynchronous active-high reset
//   bus    : slave side of pipelined_functional_unit_if (see interface)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_functional_unit #(
    parameter int WIDTH       = 32,
    parameter int MADD_STAGES = 2
) (
    input  wire logic                    CLOCK,
    input  wire logic                    RESET,
    pipelined_functional_unit_if.slave   bus
);

    localparam int c_shw   = $clog2(WIDTH);
    localparam int c_cnt_w = $clog2(MADD_STAGES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MADD_STAGES);

    localparam logic [1:0] c_unit_alu  = 2'b00;
    localparam logic [1:0] c_unit_shf  = 2'b01;
    localparam logic [1:0] c_unit_madd = 2'b10;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_madd_busy = 2'd1;
    localparam logic [1:0] c_st_hold      = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state_q,     state_d;
    logic [c_cnt_w-1:0] cnt_q,       cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   z_q,         z_d;
    logic [3:0]         flags_q,     flags_d;
    logic [WIDTH-1:0]   alu_a_q,     alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,     alu_b_d;
    logic [WIDTH-1:0]   shf_a_q,     shf_a_d;
    logic [c_shw-1:0]   shf_amt_q,   shf_amt_d;
    logic [WIDTH-1:0]   madd_a_q,    madd_a_d;
    logic [WIDTH-1:0]   madd_b_q,    madd_b_d;
    logic [WIDTH-1:0]   madd_c_q,    madd_c_d;
    logic [WIDTH-1:0]   pipe_q [MADD_STAGES];
    logic [WIDTH-1:0]   pipe_d [MADD_STAGES];

    // ------------------------------------------------------------------
    // Control wires
    // ------------------------------------------------------------------
    logic [1:0] w_unit;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_out_fire;
    logic       w_madd_adv;
    logic       w_madd_done;
    logic       w_madd_load;
    logic       w_alu_load;
    logic       w_shf_load;

    assign w_unit = bus.INST[4:3];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK or posedge RESET) begin : p_state_reg
        if (RESET) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    state_d = (w_unit == c_unit_madd) ? c_st_madd_busy : c_st_hold;
                end
            end
            c_st_madd_busy: begin
                if (w_madd_done) begin
                    state_d = c_st_hold;
                end
            end
            c_st_hold: begin
                // A new 1-cycle op in HOLD keeps us in HOLD with a fresh result
                if (w_accept) begin
                    state_d = (w_unit == c_unit_madd) ? c_st_madd_busy : c_st_hold;
                end else if (w_out_fire) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / strobes
    // ------------------------------------------------------------------
    always_comb begin : p_ctrl_out
        // RESET gates IN_READY directly so it is low while reset is held
        w_in_ready  = !RESET && (state_q != c_st_madd_busy) &&
                      (!out_valid_q || bus.OUT_READY);
        w_accept    = w_in_ready && bus.IN_VALID;
        w_out_fire  = out_valid_q && bus.OUT_READY;
        w_madd_adv  = (state_q == c_st_madd_busy);
        // Counter reaches zero one cycle before the result is registered,
        // giving MADD_STAGES+1 busy cycles in total
        w_madd_done = w_madd_adv && (cnt_q == '0);
        w_madd_load = w_accept && (w_unit == c_unit_madd);
        w_alu_load  = w_accept && (w_unit == c_unit_alu);
        w_shf_load  = w_accept && (w_unit == c_unit_shf);
    end

    // ------------------------------------------------------------------
    // ALU: live operands on acceptance, otherwise held values
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_alu_a, w_alu_b, w_alu_z;
    logic [WIDTH:0]   w_add_full, w_sub_full;
    logic             w_alu_c, w_alu_v, w_slt;

    assign w_alu_a = w_alu_load ? bus.A : alu_a_q;
    assign w_alu_b = w_alu_load ? bus.B : alu_b_q;
    assign w_slt   = $signed(w_alu_a) < $signed(w_alu_b);

    always_comb begin : p_alu
        w_add_full = {1'b0, w_alu_a} + {1'b0, w_alu_b};
        w_sub_full = {1'b0, w_alu_a} - {1'b0, w_alu_b};
        w_alu_z    = '0;
        w_alu_c    = 1'b0;
        w_alu_v    = 1'b0;
        case (bus.INST[2:0])
            3'b000: begin
                w_alu_z = w_add_full[WIDTH-1:0];
                w_alu_c = w_add_full[WIDTH];
                w_alu_v = (w_alu_a[WIDTH-1] == w_alu_b[WIDTH-1]) &&
                          (w_add_full[WIDTH-1] != w_alu_a[WIDTH-1]);
            end
            3'b001: begin
                w_alu_z = w_sub_full[WIDTH-1:0];
                w_alu_c = !w_sub_full[WIDTH];     // no borrow: A >= B
                w_alu_v = (w_alu_a[WIDTH-1] != w_alu_b[WIDTH-1]) &&
                          (w_sub_full[WIDTH-1] != w_alu_a[WIDTH-1]);
            end
            3'b010:  w_alu_z = w_alu_a & w_alu_b;
            3'b011:  w_alu_z = w_alu_a | w_alu_b;
            3'b100:  w_alu_z = w_alu_a ^ w_alu_b;
            3'b101:  w_alu_z = ~w_alu_a;
            3'b110:  w_alu_z = w_alu_a;
            default: w_alu_z = {{(WIDTH-1){1'b0}}, w_slt};
        endcase
    end

    // ------------------------------------------------------------------
    // Shifter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]        w_shf_a, w_shf_z;
    logic signed [WIDTH-1:0] w_shf_sa;
    logic [c_shw-1:0]        w_shf_amt;

    assign w_shf_a   = w_shf_load ? bus.A : shf_a_q;
    assign w_shf_amt = w_shf_load ? bus.B[c_shw-1:0] : shf_amt_q;
    assign w_shf_sa  = $signed(w_shf_a);

    always_comb begin : p_shifter
        w_shf_z = w_shf_a;
        if (!bus.INST[0]) begin
            w_shf_z = w_shf_a << w_shf_amt;
        end else if (bus.INST[1]) begin
            w_shf_z = $unsigned(w_shf_sa >>> w_shf_amt);
        end else begin
            w_shf_z = w_shf_a >> w_shf_amt;
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle result select (reserved unit falls out as Z=0, Zf=1)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_fast_z;
    logic [3:0]       w_fast_flags;
    logic             w_fast_c, w_fast_v;

    always_comb begin : p_fast_result
        w_fast_z = '0;
        w_fast_c = 1'b0;
        w_fast_v = 1'b0;
        case (w_unit)
            c_unit_alu: begin
                w_fast_z = w_alu_z;
                w_fast_c = w_alu_c;
                w_fast_v = w_alu_v;
            end
            c_unit_shf: w_fast_z = w_shf_z;
            default:    w_fast_z = '0;
        endcase
        w_fast_flags = {w_fast_z[WIDTH-1], (w_fast_z == '0), w_fast_c, w_fast_v};
    end

    // ------------------------------------------------------------------
    // Multiply-add pipeline
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_madd_res, w_madd_out;

    assign w_madd_res = madd_a_q * madd_b_q + madd_c_q;
    assign w_madd_out = pipe_q[MADD_STAGES-1];

    always_comb begin : p_madd_next
        madd_a_d = madd_a_q;
        madd_b_d = madd_b_q;
        madd_c_d = madd_c_q;
        pipe_d   = pipe_q;
        if (w_madd_load) begin
            madd_a_d = bus.A;
            madd_b_d = bus.B;
            madd_c_d = bus.C;
        end
        if (w_madd_adv) begin
            pipe_d[0] = w_madd_res;
            for (int i = 1; i < MADD_STAGES; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter, held operands and output register next values
    // ------------------------------------------------------------------
    always_comb begin : p_dp_next
        cnt_d       = cnt_q;
        alu_a_d     = w_alu_a;
        alu_b_d     = w_alu_b;
        shf_a_d     = w_shf_a;
        shf_amt_d   = w_shf_amt;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;

        if (w_madd_load) begin
            cnt_d = c_cnt_load;
        end else if (w_madd_adv && (cnt_q != '0)) begin
            cnt_d = cnt_q - c_cnt_w'(1);
        end

        if (w_out_fire) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (w_unit != c_unit_madd) begin
                out_valid_d = 1'b1;
                z_d         = w_fast_z;
                flags_d     = w_fast_flags;
            end
        end else if (w_madd_done) begin
            out_valid_d = 1'b1;
            z_d         = w_madd_out;
            flags_d     = {w_madd_out[WIDTH-1], (w_madd_out == '0), 2'b00};
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin : p_dp_reg
        if (RESET) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            shf_a_q     <= '0;
            shf_amt_q   <= '0;
            madd_a_q    <= '0;
            madd_b_q    <= '0;
            madd_c_q    <= '0;
            for (int i = 0; i < MADD_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            shf_a_q     <= shf_a_d;
            shf_amt_q   <= shf_amt_d;
            madd_a_q    <= madd_a_d;
            madd_b_q    <= madd_b_d;
            madd_c_q    <= madd_c_d;
            pipe_q      <= pipe_d;
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.Z         = z_q;
    assign bus.FLAGS     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_functional_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_functional_unit
// Description : Self-checking bench for pipelined_functional_unit
//               (WIDTH=32, MADD_STAGES=2): vector table, directed multi-cycle
//               sequences and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_functional_unit;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    pipelined_functional_unit_if #(.WIDTH(32)) bif ();

    pipelined_functional_unit #(
        .WIDTH       (32),
        .MADD_STAGES (S)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bif)
    );

    typedef struct packed {
        logic [4:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
        int          ready;
        bit          madd;
    } exp_t;

    vec_t vecs [18];
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] inst, input logic [31:0] a, b, c);
        bif.INST     = inst;
        bif.A        = a;
        bif.B        = b;
        bif.C        = c;
        bif.IN_VALID = 1'b1;
    endtask

    // Reference: {Z, N, Zf, C, V} from plain arithmetic
    function automatic logic [35:0] model(input logic [4:0] inst, input logic [31:0] a, b, c);
        logic [31:0]        z;
        logic signed [31:0] zs;
        logic               cf, vf, arith;
        longint             sa, sb, sr;
        longint unsigned    ua, ub;
        int                 amt;
        z = 0; cf = 0; vf = 0; arith = 0; sr = 0;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        amt = int'(b[4:0]);
        case (inst[4:3])
            2'b00: case (inst[2:0])
                3'd0: begin z = a + b; cf = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb; arith = 1; end
                3'd1: begin z = a - b; cf = (ua >= ub); sr = sa - sb; arith = 1; end
                3'd2: z = a & b;
                3'd3: z = a | b;
                3'd4: z = a ^ b;
                3'd5: z = ~a;
                3'd6: z = a;
                default: z = (sa < sb) ? 32'd1 : 32'd0;
            endcase
            2'b01: begin
                if (!inst[0])     z = a << amt;
                else if (inst[1]) z = a[31] ? ~((~a) >> amt) : (a >> amt);
                else              z = a >> amt;
            end
            2'b10: z = a * b + c;
            default: z = 0;
        endcase
        zs = z;
        if (arith) vf = (sr != zs);
        return {z, z[31], (z == 0), cf, vf};
    endfunction

    initial begin
        logic [35:0] m;
        logic        exp_valid, exp_busy, exp_rdy;
        logic [4:0]  inst;
        logic [31:0] ra, rb, rc;
        logic [31:0] specials [4];
        exp_t        e;

        vecs[0]  = '{5'b00000, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b0110};
        vecs[1]  = '{5'b00001, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0011};
        vecs[2]  = '{5'b01011, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 4'b1000};
        vecs[3]  = '{5'b00000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001};
        vecs[4]  = '{5'b00001, 32'd5,         32'd7,         32'hFFFF_FFFE, 4'b1000};
        vecs[5]  = '{5'b00010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 4'b0000};
        vecs[6]  = '{5'b00011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4'b1000};
        vecs[7]  = '{5'b00100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,         4'b0100};
        vecs[8]  = '{5'b00101, 32'h0,         32'h1234,      32'hFFFF_FFFF, 4'b1000};
        vecs[9]  = '{5'b00110, 32'h1234_5678, 32'hFFFF,      32'h1234_5678, 4'b0000};
        vecs[10] = '{5'b00111, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000};
        vecs[11] = '{5'b00111, 32'h1,         32'hFFFF_FFFF, 32'h0,         4'b0100};
        vecs[12] = '{5'b01000, 32'h1,         32'd31,        32'h8000_0000, 4'b1000};
        vecs[13] = '{5'b01001, 32'h8000_0000, 32'd4,         32'h0800_0000, 4'b0000};
        vecs[14] = '{5'b01011, 32'h8000_0001, 32'h20,        32'h8000_0001, 4'b1000};
        vecs[15] = '{5'b01101, 32'hF000_0000, 32'd4,         32'h0F00_0000, 4'b0000};
        vecs[16] = '{5'b11000, 32'h1234_5678, 32'h9,         32'h0,         4'b0100};
        vecs[17] = '{5'b00001, 32'd3,         32'd3,         32'h0,         4'b0110};

        rst = 1'b1;
        bif.IN_VALID = 0; bif.OUT_READY = 0;
        bif.A = 0; bif.B = 0; bif.C = 0; bif.INST = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bif.OUT_VALID, 0);
        chk("rst_z", bif.Z, 0);
        chk("rst_flags", bif.FLAGS, 0);
        chk("rst_in_ready", bif.IN_READY, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", bif.IN_READY, 1);

        // Table of single-cycle ops, issued back to back
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].inst, vecs[i].a, vecs[i].b, 32'h0);
            bif.OUT_READY = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), bif.IN_READY, 1);
            @(posedge clk);
            #1;
            bif.IN_VALID = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), bif.OUT_VALID, 1);
            chk($sformatf("vec%0d_z", i), bif.Z, vecs[i].z);
            chk($sformatf("vec%0d_flags", i), bif.FLAGS, vecs[i].f);
        end

        // MADD 3*5+7, issued while the last table result is consumed
        @(negedge clk);
        drive(5'b10000, 32'd3, 32'd5, 32'd7);
        bif.OUT_READY = 1'b1;
        #1;
        chk("madd_in_ready", bif.IN_READY, 1);
        @(posedge clk);
        #1;
        bif.IN_VALID = 1'b0;
        chk("madd_t0_out_valid", bif.OUT_VALID, 0);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("madd_t%0d_in_ready", k), bif.IN_READY, 0);
            chk($sformatf("madd_t%0d_out_valid", k), bif.OUT_VALID, 0);
        end
        @(posedge clk);
        #1;
        chk("madd_t3_out_valid", bif.OUT_VALID, 1);
        chk("madd_z", bif.Z, 22);
        chk("madd_flags", bif.FLAGS, 0);

        // AND result stalled for 4 cycles; offered ADD must be ignored
        @(negedge clk);
        drive(5'b00010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0);
        bif.OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        chk("and_out_valid", bif.OUT_VALID, 1);
        chk("and_z", bif.Z, 32'h0F0F_0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bif.OUT_READY = 1'b0;
            drive(5'b00000, 32'd1, 32'd1, 32'd0);
            #1;
            chk($sformatf("stall%0d_in_ready", k), bif.IN_READY, 0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_out_valid", k), bif.OUT_VALID, 1);
            chk($sformatf("stall%0d_z", k), bif.Z, 32'h0F0F_0000);
            chk($sformatf("stall%0d_flags", k), bif.FLAGS, 4'b0000);
        end
        @(negedge clk);
        bif.IN_VALID  = 1'b0;
        bif.OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        chk("ignored_op_no_result", bif.OUT_VALID, 0);

        // Full-throughput stream of single-cycle ops
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(5'b00000, 32'(k * 3), 32'd100, 32'd0);
            bif.OUT_READY = 1'b1;
            #1;
            chk($sformatf("stream%0d_in_ready", k), bif.IN_READY, 1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_out_valid", k), bif.OUT_VALID, 1);
            chk($sformatf("stream%0d_z", k), bif.Z, 32'(k * 3 + 100));
        end

        // Reset one cycle into a MADD discards it
        @(negedge clk);
        drive(5'b10000, 32'd9, 32'd9, 32'd9);
        @(negedge clk);
        bif.IN_VALID = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", bif.OUT_VALID, 0);
        chk("async_rst_in_ready", bif.IN_READY, 0);
        chk("async_rst_z", bif.Z, 0);
        chk("async_rst_flags", bif.FLAGS, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_out_valid", k), bif.OUT_VALID, 0);
        end
        @(negedge clk);
        drive(5'b00000, 32'd1, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bif.IN_VALID = 1'b0;
        chk("post_rst_add_valid", bif.OUT_VALID, 1);
        chk("post_rst_add_z", bif.Z, 2);
        chk("post_rst_add_flags", bif.FLAGS, 0);

        // Drain, then randomized traffic against the reference model
        @(negedge clk);
        bif.IN_VALID  = 1'b0;
        bif.OUT_READY = 1'b1;
        repeat (2) @(posedge clk);
        specials[0] = 32'h0;
        specials[1] = 32'h8000_0000;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'hFFFF_FFFF;

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            inst = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            ra   = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            rb   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rc   = $urandom;
            drive(inst, ra, rb, rc);
            bif.IN_VALID  = ($urandom_range(0, 3) != 0);
            bif.OUT_READY = ($urandom_range(0, 3) != 0);
            #1;
            exp_valid = (q.size() > 0) && (cycle >= q[0].ready);
            exp_busy  = (q.size() > 0) && q[0].madd && (cycle < q[0].ready);
            exp_rdy   = !exp_busy && (!exp_valid || bif.OUT_READY);
            chk("rnd_out_valid", bif.OUT_VALID, exp_valid);
            chk("rnd_in_ready", bif.IN_READY, exp_rdy);
            if (exp_valid) begin
                chk("rnd_z", bif.Z, q[0].z);
                chk("rnd_flags", bif.FLAGS, q[0].f);
                if (bif.OUT_READY) void'(q.pop_front());
            end
            if (bif.IN_VALID && exp_rdy) begin
                m      = model(inst, ra, rb, rc);
                e.z    = m[35:4];
                e.f    = m[3:0];
                e.madd = (inst[4:3] == 2'b10);
                e.ready = cycle + 1 + (e.madd ? S + 1 : 0);
                q.push_back(e);
            end
        end

        bif.IN_VALID = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
